// File: rtl/sid_bus_pkg.sv
// Shared definitions for the SID register-bus initiator: register map,
// request word layout and bus FSM states.
package sid_bus_pkg;

  // Voice-1 register offsets; voices 2 and 3 repeat the block at +7 and +14
  typedef enum logic [4:0] {
    REG_FREQ_LO  = 5'd0,
    REG_FREQ_HI  = 5'd1,
    REG_PW_LO    = 5'd2,
    REG_PW_HI    = 5'd3,
    REG_CTRL     = 5'd4,
    REG_AD       = 5'd5,
    REG_SR       = 5'd6,
    REG_FC_LO    = 5'd21,
    REG_FC_HI    = 5'd22,
    REG_RES_FILT = 5'd23,
    REG_MODE_VOL = 5'd24,
    REG_POT_X    = 5'd25,
    REG_POT_Y    = 5'd26,
    REG_OSC3     = 5'd27,
    REG_ENV3     = 5'd28
  } sid_reg_e;

  localparam int SID_SEL_BIT = 5;
  localparam int REQ_W       = 15;

  typedef struct packed {
    logic       rw;
    logic [5:0] addr;
    logic [7:0] data;
  } req_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_HOLD} state_t;

  function automatic req_t pack_req(input logic rw, input logic [5:0] addr,
                                    input logic [7:0] data);
    req_t r;
    r.rw   = rw;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/sid_req_fifo.sv
// Synchronous first-word-fall-through request FIFO; callers gate push/pop
// with full/empty.
module sid_req_fifo
  import sid_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  req_t wdata_i,
  input  logic pop_i,
  output req_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Extra pointer bit distinguishes full from empty when indices match
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = req_t'(mem_q[rd_ptr_q[AW-1:0]]);

endmodule

// File: rtl/sid_bus_master.sv
// 6502-style bus initiator for the SID register interface: free-running phi2,
// one queued access per phi2 period, read data returned as a one-cycle pulse.
module sid_bus_master
  import sid_bus_pkg::*;
#(
  parameter int HALF_CYC   = 8,
  parameter int HOLD_CYC   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       phi2,
  output logic       CEb,
  output logic       RWb,
  output logic [5:0] reg_addr,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       busy
);

  localparam int CW = $clog2(HALF_CYC);
  localparam logic [CW-1:0] CNT_LAST   = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] CNT_LAUNCH = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [CW-1:0] cnt_q;
  logic          phi2_q;
  state_t        state_q, state_d;
  logic          ceb_q, ceb_d, rwb_q, rwb_d, oe_q, oe_d;
  logic [5:0]    addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rdy_en_q;

  req_t head, push_word;
  logic fifo_full, fifo_empty, push, pop;
  logic wrap, rise, fall, launch;

  assign wrap   = (cnt_q == CNT_LAST);
  assign rise   = wrap && !phi2_q;
  assign fall   = wrap && phi2_q;
  // HOLD_CYC clocks of phi2-low have elapsed once this edge completes
  assign launch = !phi2_q && (cnt_q == CNT_LAUNCH);
  assign pop    = launch && !fifo_empty &&
                  ((state_q == ST_IDLE) || (state_q == ST_HOLD));

  assign req_ready = rdy_en_q && !fifo_full;
  assign push      = req_valid && req_ready;
  assign push_word = pack_req(req_rw, req_addr, req_data);

  sid_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      phi2_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      cnt_q    <= wrap ? '0 : cnt_q + CNT_ONE;
      phi2_q   <= wrap ? !phi2_q : phi2_q;
      rdy_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pop)    state_d = ST_ADDR;
      ST_ADDR: if (rise)   state_d = ST_DATA;
      ST_DATA: if (fall)   state_d = ST_HOLD;
      ST_HOLD: if (launch) state_d = fifo_empty ? ST_IDLE : ST_ADDR;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ceb_d       = ceb_q;
    rwb_d       = rwb_q;
    oe_d        = oe_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    if (pop) begin
      ceb_d  = 1'b0;
      rwb_d  = head.rw;
      addr_d = head.addr;
      dout_d = head.data;
      oe_d   = !head.rw;
    end else if ((state_q == ST_HOLD) && launch) begin
      ceb_d = 1'b1;
      rwb_d = 1'b1;
      oe_d  = 1'b0;
    end
    // bus_in during the last phi2-high clock is captured on the falling edge
    if ((state_q == ST_DATA) && fall && rwb_q) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = bus_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ceb_q       <= 1'b1;
      rwb_q       <= 1'b1;
      oe_q        <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      ceb_q       <= ceb_d;
      rwb_q       <= rwb_d;
      oe_q        <= oe_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign phi2      = phi2_q;
  assign CEb       = ceb_q;
  assign RWb       = rwb_q;
  assign bus_oe    = oe_q;
  assign reg_addr  = addr_q;
  assign bus_out   = dout_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sid_bus_master.sv
// Directed bench for sid_bus_master with a behavioural register target and a
// scoreboard of expected bus accesses and read responses.
module tb_sid_bus_master;
  import sid_bus_pkg::*;

  localparam int HALF = 8;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_rw = 1'b0;
  logic [5:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, rsp_valid, phi2, CEb, RWb, bus_oe, busy;
  logic [7:0] rsp_data, bus_out, bus_in;
  logic [5:0] reg_addr;

  sid_bus_master #(.HALF_CYC(HALF), .HOLD_CYC(HOLD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .phi2(phi2), .CEb(CEb),
    .RWb(RWb), .reg_addr(reg_addr), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_in(bus_in), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] tmem   [64];
  logic [7:0] shadow [64];
  assign bus_in = tmem[reg_addr];

  req_t       exp_bus [$];
  logic [7:0] exp_rsp [$];
  int         stamps  [$];
  int         runs    [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and target: accesses complete on the phi2 falling edge
  logic        prev_phi2 = 1'b0, prev_ceb = 1'b1;
  logic [15:0] prev_bus = '0;
  int          lowcnt = 0, ceb_run = 0;
  always @(negedge clk) begin
    logic fall_now, exp_pulse;
    req_t e;
    if (!rst_n) begin
      lowcnt = 0; prev_phi2 = 1'b0; prev_ceb = 1'b1; ceb_run = 0;
    end else begin
      lowcnt    = phi2 ? 0 : lowcnt + 1;
      fall_now  = prev_phi2 && !phi2;
      if (CEb !== prev_ceb) check("launch_align", lowcnt, HOLD + 1);
      if (!CEb && prev_ceb) check("oe_launch", bus_oe, !RWb);
      if (!CEb && !prev_ceb && lowcnt != HOLD + 1)
        check("bus_stable", {RWb, bus_oe, reg_addr, bus_out}, prev_bus);
      exp_pulse = fall_now && !CEb && RWb;
      if (rsp_valid || exp_pulse) check("rsp_pulse", rsp_valid, exp_pulse);
      if (fall_now && !CEb) begin
        stamps.push_back(cyc);
        check("xact_expected", exp_bus.size() > 0, 1);
        if (exp_bus.size() > 0) begin
          e = exp_bus.pop_front();
          check("xact", {RWb, reg_addr, bus_out}, {e.rw, e.addr, e.data});
          check("oe_xact", bus_oe, !RWb);
        end
        if (!RWb) tmem[reg_addr] = bus_out;
        else begin
          check("rsp_expected", exp_rsp.size() > 0, 1);
          if (exp_rsp.size() > 0) check("rsp_data", rsp_data, exp_rsp.pop_front());
        end
      end
      if (!CEb) ceb_run++;
      else if (!prev_ceb) begin runs.push_back(ceb_run); ceb_run = 0; end
      prev_phi2 = phi2;
      prev_ceb  = CEb;
      prev_bus  = {RWb, bus_oe, reg_addr, bus_out};
    end
  end

  task automatic send(input logic rw, input logic [5:0] a, input logic [7:0] d);
    logic acc;
    int   n;
    req_t e;
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = d; n = 0;
    do begin
      acc = req_ready;
      @(posedge clk);
      n++;
    end while (!acc && n < 200);
    #1 req_valid = 1'b0;
    check("accept", acc, 1);
    if (acc) begin
      e.rw = rw; e.addr = a; e.data = d;
      exp_bus.push_back(e);
      if (rw) exp_rsp.push_back(shadow[a]);
      else    shadow[a] = d;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin @(posedge clk); #1; n++; end
    check("idle_timeout", busy, 0);
    @(negedge clk); #1;
  endtask

  initial begin
    logic [7:0] old_t, old_s;
    int n;
    for (int i = 0; i < 64; i++) begin tmem[i] = 8'h00; shadow[i] = 8'h00; end
    tmem[{1'b0, REG_POT_X}]   = 8'hA5;
    shadow[{1'b0, REG_POT_X}] = 8'hA5;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_phi2", phi2, 0);         check("rst_CEb", CEb, 1);
    check("rst_RWb", RWb, 1);           check("rst_reg_addr", reg_addr, 0);
    check("rst_bus_out", bus_out, 0);   check("rst_bus_oe", bus_oe, 0);
    check("rst_rsp_valid", rsp_valid, 0); check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);         check("rst_req_ready", req_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", req_ready, 1);

    // Single write, SID0 CTRL
    send(1'b0, 6'h04, 8'h41);
    wait_idle();
    check("t1_target", tmem[6'h04], 8'h41);
    check("t1_ceb_len", runs.size() > 0 ? runs[runs.size()-1] : -1, 2 * HALF);

    // SID1 MODE_VOL only
    send(1'b0, 6'h38, 8'h0F);
    send(1'b1, 6'h38, 8'h00);
    send(1'b1, {1'b0, REG_MODE_VOL}, 8'h00);
    wait_idle();
    check("t2_sid1", tmem[6'h38], 8'h0F);
    check("t2_sid0", tmem[6'h18], 8'h00);
    check("t2_sel_bit", tmem[6'(1 << SID_SEL_BIT) | 6'h18], 8'h0F);

    // POT X readback
    send(1'b1, {1'b0, REG_POT_X}, 8'h00);
    wait_idle();
    check("t3_rsp_hold", rsp_data, 8'hA5);

    // Five writes without stalls, launched in consecutive phi2 periods
    n = 0;
    while (phi2 && n < 100) begin @(posedge clk); #1; n++; end
    while (!phi2 && n < 100) begin @(posedge clk); #1; n++; end
    check("t4_sync", phi2, 1);
    stamps.delete();
    for (int i = 0; i < 4; i++) send(1'b0, 6'(8 + i), 8'(8'hA0 + i));
    check("t4_full", req_ready, 0);
    send(1'b0, 6'h0C, 8'hA4);
    wait_idle();
    check("t4_count", stamps.size(), 5);
    for (int i = 0; i < 4 && i + 1 < stamps.size(); i++)
      check("t4_spacing", stamps[i+1] - stamps[i], 2 * HALF);

    // Mixed traffic
    send(1'b0, 6'h01, 8'h11);
    send(1'b1, 6'h01, 8'h00);
    send(1'b0, 6'h1F, 8'h22);
    send(1'b1, {1'b0, REG_POT_X}, 8'h00);
    send(1'b1, 6'h1F, 8'h00);
    wait_idle();
    check("t5_w1", tmem[6'h01], 8'h11);
    check("t5_w2", tmem[6'h1F], 8'h22);

    // Reset in the middle of a write's phi2-high phase
    old_t = tmem[6'h05];
    old_s = shadow[6'h05];
    send(1'b0, 6'h05, 8'h77);
    n = 0;
    while (!(!CEb && phi2) && n < 100) begin @(negedge clk); n++; end
    check("t6_in_data", {CEb, phi2}, 2'b01);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_CEb", CEb, 1);       check("t6_phi2", phi2, 0);
    check("t6_bus_oe", bus_oe, 0); check("t6_RWb", RWb, 1);
    check("t6_rsp_valid", rsp_valid, 0);
    exp_bus.delete();
    exp_rsp.delete();
    shadow[6'h05] = old_s;
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (HALF - 1) @(posedge clk);
    #1;
    check("t6_phi2_low", phi2, 0);
    check("t6_busy", busy, 0);
    @(posedge clk); #1;
    check("t6_phi2_rise", phi2, 1);
    check("t6_target", tmem[6'h05], old_t);
    send(1'b1, 6'h05, 8'h00);
    wait_idle();

    check("sb_bus_empty", exp_bus.size(), 0);
    check("sb_rsp_empty", exp_rsp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
